// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared constants for the serial pattern detectors and their status blocks.
//   MIN_SEQ_LEN / MAX_SEQ_LEN : legal range of the pattern length
//   MODE_NOVL / MODE_OVL      : encodings of the overlap mode bit
//   seq_len_ok()              : elaboration-time range check helper
// ---------------------------------------------------------------------------
package seq_det_pkg;

   localparam int MIN_SEQ_LEN = 2;
   localparam int MAX_SEQ_LEN = 16;

   localparam logic MODE_NOVL = 1'b0;
   localparam logic MODE_OVL  = 1'b1;

   function automatic bit seq_len_ok(input int len);
      return (len >= MIN_SEQ_LEN) && (len <= MAX_SEQ_LEN);
   endfunction

endpackage : seq_det_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear; clear wins over increment.
// Ports:
//   clk   in  rising-edge clock
//   rst_n in  asynchronous active-low reset
//   inc   in  count up by one this edge (ignored once all-ones)
//   clr   in  synchronous clear to zero, priority over inc
//   cnt   out current count, W bits
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
// Serial pattern detector with parametrised length, runtime pattern and
// overlap mode, valid-qualified input and a saturating match counter.
// Ports:
//   clk         in  rising-edge clock
//   reset       in  asynchronous active-low reset
//   din         in  serial data bit
//   din_valid   in  din is sampled only when 1
//   cfg_we      in  load cfg_pattern/cfg_overlap, flush the window
//   cfg_pattern in  new pattern, MSB is the first bit received
//   cfg_overlap in  new mode (1 = overlapping)
//   cnt_clr     in  synchronous clear of match_cnt
//   dout        out registered one-cycle match pulse
//   match_cnt   out saturating match count
//   busy        out window holds at least one valid bit
// ---------------------------------------------------------------------------
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                 SEQ_LEN     = 3,
   parameter logic [SEQ_LEN-1:0] DEF_PATTERN = {SEQ_LEN{1'b1}},
   parameter logic               DEF_OVERLAP = MODE_OVL,
   parameter int                 CNT_W       = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_we,
   input  logic [SEQ_LEN-1:0] cfg_pattern,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               dout,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy
);

   if (!seq_len_ok(SEQ_LEN)) begin : g_bad_seq_len
      $error("seq_detector_param: SEQ_LEN out of range");
   end

   localparam int                FILL_W   = $clog2(SEQ_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SEQ_LEN);

   logic [SEQ_LEN-1:0] pattern_q, pattern_d;
   logic               overlap_q, overlap_d;
   logic [SEQ_LEN-1:0] hist_q,    hist_d;
   logic [FILL_W-1:0]  fill_q,    fill_d;
   logic               dout_q,    dout_d;
   logic               busy_q,    busy_d;

   logic [SEQ_LEN-1:0] win;
   logic [FILL_W-1:0]  fill_inc;
   logic               hit;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the if/else leaves it unassigned and no latch is inferred.
   always_comb begin
      pattern_d = pattern_q;
      overlap_d = overlap_q;
      hist_d    = hist_q;
      fill_d    = fill_q;
      dout_d    = 1'b0;
      hit       = 1'b0;

      win      = {hist_q[SEQ_LEN-2:0], din};
      fill_inc = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 1'b1;

      if (cfg_we) begin
         // Reconfiguration flushes the window; din at this edge is dropped.
         pattern_d = cfg_pattern;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
      end else if (din_valid) begin
         hist_d = win;
         // The fill check keeps stale history (e.g. zeros after reset)
         // from matching before SEQ_LEN real bits have arrived.
         hit    = (win == pattern_q) && (fill_inc == FILL_MAX);
         dout_d = hit;
         if (hit && (overlap_q == MODE_NOVL)) begin
            fill_d = '0;
         end else begin
            fill_d = fill_inc;
         end
      end

      busy_d = (fill_d != '0);
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples its _d value from before this edge, independent of order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pattern_q <= DEF_PATTERN;
         overlap_q <= DEF_OVERLAP;
         hist_q    <= '0;
         fill_q    <= '0;
         dout_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         pattern_q <= pattern_d;
         overlap_q <= overlap_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         dout_q    <= dout_d;
         busy_q    <= busy_d;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst_n (reset),
      .inc   (hit),
      .clr   (cnt_clr),
      .cnt   (match_cnt)
   );

   assign dout = dout_q;
   assign busy = busy_q;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
// Two detectors (CNT_W=8 and CNT_W=2) share one stimulus stream. Each driven
// edge is run through a behavioural model and its expected outputs are queued;
// after the edge the entry is popped and compared against both instances.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

   logic       clk = 1'b0;
   logic       reset;
   logic       din;
   logic       din_valid;
   logic       cfg_we;
   logic [2:0] cfg_pattern;
   logic       cfg_overlap;
   logic       cnt_clr;

   logic       dout_a, busy_a;
   logic [7:0] cnt_a;
   logic       dout_b, busy_b;
   logic [1:0] cnt_b;

   always #5 clk = ~clk;

   seq_detector_param #(
      .SEQ_LEN     (3),
      .DEF_PATTERN (3'b111),
      .DEF_OVERLAP (1'b1),
      .CNT_W       (8)
   ) dut_a (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .dout        (dout_a),
      .match_cnt   (cnt_a),
      .busy        (busy_a)
   );

   seq_detector_param #(
      .SEQ_LEN     (3),
      .DEF_PATTERN (3'b111),
      .DEF_OVERLAP (1'b1),
      .CNT_W       (2)
   ) dut_b (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .cfg_we      (cfg_we),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .cnt_clr     (cnt_clr),
      .dout        (dout_b),
      .match_cnt   (cnt_b),
      .busy        (busy_b)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- model ----------------
   typedef struct {
      logic       dout;
      logic [7:0] cnt8;
      logic [1:0] cnt2;
      logic       busy;
   } exp_t;

   exp_t exp_q[$];

   int m_pat, m_ovl, m_hist, m_fill, m_cnt8, m_cnt2, m_dout;

   task automatic model_reset();
      m_pat  = 7;
      m_ovl  = 1;
      m_hist = 0;
      m_fill = 0;
      m_cnt8 = 0;
      m_cnt2 = 0;
      m_dout = 0;
   endtask

   task automatic model_edge(input bit v, input bit d, input bit we,
                             input int p, input bit o, input bit clr);
      bit hit;
      int nf;
      hit = 1'b0;
      if (we) begin
         m_pat  = p;
         m_ovl  = o;
         m_hist = 0;
         m_fill = 0;
         m_dout = 0;
      end else if (v) begin
         m_hist = ((m_hist << 1) | int'(d)) & 7;
         nf     = (m_fill < 3) ? m_fill + 1 : 3;
         hit    = (m_hist == m_pat) && (nf == 3);
         m_dout = hit;
         m_fill = (hit && m_ovl == 0) ? 0 : nf;
      end else begin
         m_dout = 0;
      end
      if (clr) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (hit) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3)   m_cnt2++;
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.dout = m_dout[0];
      e.cnt8 = m_cnt8[7:0];
      e.cnt2 = m_cnt2[1:0];
      e.busy = (m_fill != 0);
      return e;
   endfunction

   task automatic compare(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_dout"},   32'(dout_a), 32'(e.dout));
         check({tag, "_cnt"},    32'(cnt_a),  32'(e.cnt8));
         check({tag, "_busy"},   32'(busy_a), 32'(e.busy));
         check({tag, "_dout2"},  32'(dout_b), 32'(e.dout));
         check({tag, "_cnt2"},   32'(cnt_b),  32'(e.cnt2));
      end
   endtask

   // One clock edge of stimulus: drive at negedge, queue expectation,
   // sample #1 after the rising edge.
   task automatic step(input string tag, input bit v, input bit d,
                       input bit we = 1'b0, input logic [2:0] p = 3'b000,
                       input bit o = 1'b0, input bit clr = 1'b0);
      @(negedge clk);
      din         = d;
      din_valid   = v;
      cfg_we      = we;
      cfg_pattern = p;
      cfg_overlap = o;
      cnt_clr     = clr;
      model_edge(v, d, we, int'(p), o, clr);
      exp_q.push_back(model_out());
      @(posedge clk);
      #1;
      compare(tag);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge clk);
      din_valid = 1'b0;
      cfg_we    = 1'b0;
      cnt_clr   = 1'b0;
      reset     = 1'b0;
      #1;
      model_reset();
      // Asynchronous clear must be visible before any clock edge.
      check({tag, "_async_dout"}, 32'(dout_a), 32'd0);
      check({tag, "_async_cnt"},  32'(cnt_a),  32'd0);
      check({tag, "_async_busy"}, 32'(busy_a), 32'd0);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b0;
      din         = 1'b0;
      din_valid   = 1'b0;
      cfg_we      = 1'b0;
      cfg_pattern = 3'b000;
      cfg_overlap = 1'b0;
      cnt_clr     = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_dout",  32'(dout_a), 32'd0);
      check("rst_cnt",   32'(cnt_a),  32'd0);
      check("rst_busy",  32'(busy_a), 32'd0);
      check("rst_cnt2",  32'(cnt_b),  32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 1: default 111 overlapping, five ones -> three back-to-back pulses.
      for (int i = 0; i < 5; i++) step($sformatf("t1_b%0d", i), 1'b1, 1'b1);
      check("t1_final_cnt", 32'(cnt_a), 32'd3);

      // 2: non-overlapping 111, six ones -> pulses after bits 3 and 6.
      step("t2_cfg", 1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
      step("t2_clr", 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step($sformatf("t2_b%0d", i), 1'b1, 1'b1);
      check("t2_final_cnt", 32'(cnt_a), 32'd2);

      // 3: pattern 101 overlapping with valid gaps.
      step("t3_cfg", 1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
      begin
         bit bits3 [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
         for (int i = 0; i < 5; i++) begin
            step($sformatf("t3_v%0d", i), 1'b1, bits3[i]);
            step($sformatf("t3_g%0d", i), 1'b0, ~bits3[i]);
         end
      end

      // 4: reset mid-pattern discards partial history and restores defaults.
      step("t4_b0", 1'b1, 1'b1);
      step("t4_b1", 1'b1, 1'b1);
      pulse_reset("t4");
      for (int i = 0; i < 3; i++) step($sformatf("t4_p%0d", i), 1'b1, 1'b1);

      // 5: narrow counter saturates; clear beats a simultaneous hit.
      pulse_reset("t5");
      for (int i = 0; i < 10; i++) step($sformatf("t5_b%0d", i), 1'b1, 1'b1);
      check("t5_sat_cnt2", 32'(cnt_b), 32'd3);
      step("t5_clr_hit", 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
      check("t5_clr_dout", 32'(dout_b), 32'd1);

      // 6: reconfiguring mid-pattern flushes the window.
      pulse_reset("t6");
      step("t6_b0", 1'b1, 1'b1);
      step("t6_b1", 1'b1, 1'b1);
      step("t6_cfg", 1'b1, 1'b1, 1'b1, 3'b111, 1'b1);
      for (int i = 0; i < 4; i++) step($sformatf("t6_p%0d", i), 1'b1, 1'b1);

      // Random mix including the all-zeros pattern.
      step("rnd_cfg0", 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
      for (int i = 0; i < 80; i++) begin
         bit we_r;
         we_r = ($urandom_range(0, 11) == 0);
         step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              we_r, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_seq_detector_param
